// File: rtl/imem_boot_sequencer.sv
// Boot-time front end: streams host program words into instruction memory,
// then holds the processor's working enable for a programmed number of cycles.
module imem_boot_sequencer #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic              start,
  input  logic              clear,
  input  logic [CNT_W-1:0]  run_cycles,
  output logic [ADDR_W-1:0] addr,
  output logic              wEn,
  output logic [DATA_W-1:0] wDat,
  output logic              working,
  output logic [ADDR_W:0]   wr_count,
  output logic              done,
  output logic              err_full
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ARM  = 3'd2,
    RUN  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE_W     = (ADDR_W + 1)'(1);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_C   = '0;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdat_q, wdat_d;
  logic                working_q, working_d;
  logic [ADDR_W:0]     wr_count_q, wr_count_d;
  logic                done_q, done_d;
  logic                err_full_q, err_full_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  assign s_ready = (state_q == IDLE) || (state_q == LOAD);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wen_d      = 1'b0;
    wdat_d     = wdat_q;
    working_d  = working_q;
    wr_count_d = wr_count_q;
    done_d     = done_q;
    err_full_d = err_full_q;
    cnt_d      = cnt_q;

    if (clear) begin
      state_d    = IDLE;
      working_d  = 1'b0;
      wr_count_d = '0;
      done_d     = 1'b0;
      err_full_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, LOAD: begin
          if (s_valid) begin
            addr_d     = wr_count_q[ADDR_W-1:0];
            wdat_d     = s_data;
            wen_d      = 1'b1;
            wr_count_d = wr_count_q + ONE_W;
            // Filling the last slot ends the load even without s_last.
            if (s_last || (wr_count_q == LAST_ADDR)) begin
              state_d    = ARM;
              err_full_d = !s_last;
            end else begin
              state_d = LOAD;
            end
          end
        end
        ARM, DONE: begin
          if (start) begin
            cnt_d = run_cycles;
            if (run_cycles == ZERO_C) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d   = RUN;
              working_d = 1'b1;
              done_d    = 1'b0;
            end
          end
        end
        RUN: begin
          // cnt_q holds the cycles of working still owed including this one.
          if (cnt_q == ONE_C) begin
            state_d   = DONE;
            working_d = 1'b0;
            done_d    = 1'b1;
            cnt_d     = ZERO_C;
          end else begin
            cnt_d = cnt_q - ONE_C;
          end
        end
        default: begin
          state_d   = IDLE;
          working_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdat_q     <= '0;
      working_q  <= 1'b0;
      wr_count_q <= '0;
      done_q     <= 1'b0;
      err_full_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wen_q      <= wen_d;
      wdat_q     <= wdat_d;
      working_q  <= working_d;
      wr_count_q <= wr_count_d;
      done_q     <= done_d;
      err_full_q <= err_full_d;
      cnt_q      <= cnt_d;
    end
  end

  assign addr     = addr_q;
  assign wEn      = wen_q;
  assign wDat     = wdat_q;
  assign working  = working_q;
  assign wr_count = wr_count_q;
  assign done     = done_q;
  assign err_full = err_full_q;

endmodule

// File: tb/tb_imem_boot_sequencer.sv
// Directed bench for imem_boot_sequencer: a full-depth instance for load/run/clear/reset
// scenarios and a DEPTH=4 instance for the overflow case.
module tb_imem_boot_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] run_cycles = '0;
  logic [8:0]  addr;
  logic        wEn;
  logic [31:0] wDat;
  logic        working;
  logic [9:0]  wr_count;
  logic        done;
  logic        err_full;

  logic        s_valid2 = 1'b0;
  logic        s_last2 = 1'b0;
  logic        start2 = 1'b0;
  logic        clear2 = 1'b0;
  logic        s_ready2;
  logic [1:0]  addr2;
  logic        wEn2;
  logic [31:0] wDat2;
  logic        working2;
  logic [2:0]  wr_count2;
  logic        done2;
  logic        err_full2;

  int errors = 0;
  int checks = 0;

  always #10 clock = ~clock;

  imem_boot_sequencer dut (
    .clock(clock), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .start(start), .clear(clear), .run_cycles(run_cycles), .addr(addr),
    .wEn(wEn), .wDat(wDat), .working(working), .wr_count(wr_count), .done(done),
    .err_full(err_full)
  );

  imem_boot_sequencer #(.ADDR_W(2), .DATA_W(32), .DEPTH(4), .CNT_W(16)) dut4 (
    .clock(clock), .reset(reset), .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data),
    .s_last(s_last2), .start(start2), .clear(clear2), .run_cycles(run_cycles), .addr(addr2),
    .wEn(wEn2), .wDat(wDat2), .working(working2), .wr_count(wr_count2), .done(done2),
    .err_full(err_full2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) begin
      $display("check %s obs=%0h exp=%0h", tag, obs, exp);
    end else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [31:0] words [9];
  logic        gap_valid [6];
  int          n_work;
  int          seen_wen;
  int          k;

  initial begin
    words = '{32'h10f0001c, 32'h10f1001d, 32'h10f2001e, 32'h10f3001f, 32'h10f40020,
              32'h10f50021, 32'h20100000, 32'h21320000, 32'h32450000};
    gap_valid = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    // Reset values
    tick();
    check("rst_addr", 64'(addr), 64'd0);
    check("rst_wen", 64'(wEn), 64'd0);
    check("rst_wdat", 64'(wDat), 64'd0);
    check("rst_working", 64'(working), 64'd0);
    check("rst_wr_count", 64'(wr_count), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err_full", 64'(err_full), 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd1);
    reset = 1'b0;
    tick();

    // 1: nine back-to-back words
    for (int i = 0; i < 9; i++) begin
      s_valid = 1'b1;
      s_data  = words[i];
      s_last  = (i == 8);
      check($sformatf("load_ready%0d", i), 64'(s_ready), 64'd1);
      tick();
      $display("beat %0d: addr=%0d wEn=%0b wDat=%h", i, addr, wEn, wDat);
      check($sformatf("load_wen%0d", i), 64'(wEn), 64'd1);
      check($sformatf("load_addr%0d", i), 64'(addr), 64'(i));
      check($sformatf("load_wdat%0d", i), 64'(wDat), 64'(words[i]));
      check($sformatf("load_cnt%0d", i), 64'(wr_count), 64'(i + 1));
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("arm_ready", 64'(s_ready), 64'd0);
    check("arm_err_full", 64'(err_full), 64'd0);
    // A word offered in ARM must be refused.
    s_valid = 1'b1;
    s_data  = 32'hdeadbeef;
    tick();
    s_valid = 1'b0;
    check("arm_no_wen", 64'(wEn), 64'd0);
    check("arm_wr_count", 64'(wr_count), 64'd9);

    // 2: run 12 cycles, then re-run from DONE
    for (int r = 0; r < 2; r++) begin
      run_cycles = 16'd12;
      start = 1'b1;
      tick();
      start = 1'b0;
      n_work = 0;
      seen_wen = 0;
      for (int c = 0; c < 40; c++) begin
        if (done) break;
        if (working) n_work++;
        if (wEn) seen_wen++;
        tick();
      end
      $display("run %0d: working cycles=%0d done=%0b", r, n_work, done);
      check($sformatf("run%0d_cycles", r), 64'(n_work), 64'd12);
      check($sformatf("run%0d_done", r), 64'(done), 64'd1);
      check($sformatf("run%0d_working_off", r), 64'(working), 64'd0);
      check($sformatf("run%0d_no_wen", r), 64'(seen_wen), 64'd0);
      check($sformatf("run%0d_ready", r), 64'(s_ready), 64'd0);
    end

    // 3: clear (with a simultaneous beat that must be dropped), then gapped load
    clear   = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'h55aa55aa;
    tick();
    clear   = 1'b0;
    s_valid = 1'b0;
    check("clr_wen", 64'(wEn), 64'd0);
    check("clr_wr_count", 64'(wr_count), 64'd0);
    check("clr_done", 64'(done), 64'd0);
    check("clr_ready", 64'(s_ready), 64'd1);
    k = 0;
    for (int i = 0; i < 6; i++) begin
      s_valid = gap_valid[i];
      s_data  = 32'ha0 + 32'(i);
      s_last  = (i == 5);
      tick();
      $display("gap beat %0d: valid=%0b wEn=%0b addr=%0d", i, gap_valid[i], wEn, addr);
      check($sformatf("gap_wen%0d", i), 64'(wEn), 64'(gap_valid[i]));
      if (gap_valid[i]) begin
        check($sformatf("gap_addr%0d", i), 64'(addr), 64'(k));
        check($sformatf("gap_wdat%0d", i), 64'(wDat), 64'(32'ha0 + 32'(i)));
        k++;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("gap_wr_count", 64'(wr_count), 64'd3);
    check("gap_ready", 64'(s_ready), 64'd0);

    // 5: zero-length run, then clear
    run_cycles = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("zero_done", 64'(done), 64'd1);
    check("zero_working", 64'(working), 64'd0);
    tick();
    check("zero_working_hold", 64'(working), 64'd0);
    check("zero_done_hold", 64'(done), 64'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("zclr_done", 64'(done), 64'd0);
    check("zclr_err", 64'(err_full), 64'd0);
    check("zclr_wr_count", 64'(wr_count), 64'd0);
    check("zclr_ready", 64'(s_ready), 64'd1);

    // 4: DEPTH=4 instance fed 6 words without s_last
    for (int i = 0; i < 6; i++) begin
      s_valid2 = 1'b1;
      s_data   = 32'hb0 + 32'(i);
      tick();
      $display("full beat %0d: wEn=%0b addr=%0d", i, wEn2, addr2);
      check($sformatf("full_wen%0d", i), 64'(wEn2), 64'(i < 4));
      if (i < 4) check($sformatf("full_addr%0d", i), 64'(addr2), 64'(i));
    end
    s_valid2 = 1'b0;
    check("full_err", 64'(err_full2), 64'd1);
    check("full_wr_count", 64'(wr_count2), 64'd4);
    check("full_ready", 64'(s_ready2), 64'd0);

    // 6: async reset in cycle 5 of a run
    s_valid = 1'b1;
    s_last  = 1'b1;
    s_data  = 32'hc0ffee00;
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
    run_cycles = 16'd20;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("pre_rst_working", 64'(working), 64'd1);
    #4;
    reset = 1'b1;
    #1;
    check("arst_working", 64'(working), 64'd0);
    check("arst_addr", 64'(addr), 64'd0);
    check("arst_wdat", 64'(wDat), 64'd0);
    check("arst_wen", 64'(wEn), 64'd0);
    check("arst_wr_count", 64'(wr_count), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_err4", 64'(err_full2), 64'd0);
    check("arst_ready", 64'(s_ready), 64'd1);
    tick();
    reset = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
